// File: rtl/alu_pkg.sv
// Shared types and constants for the 16-bit execute-stage ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // Two's-complement subtract: invert b and inject carry-in; carry-out is then not-borrow.
    always_comb begin
        b_eff    = sub ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full_sum[WIDTH-1:0];
        carry    = full_sum[WIDTH];
    end

endmodule

// File: rtl/alu_16.sv
// Two-operand ALU (ADD/SUB/AND/OR) with registered result and carry flag.
// Latency: 1 cycle; inputs at edge N appear on ALU_Out/cOut after edge N.
// Backpressure: none; accepts a new operation every cycle, outputs update every edge.
module alu_16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             cOut
);

    alu_op_e          op;
    logic             sub_sel;
    logic [WIDTH-1:0] addsub_sum;
    logic             addsub_carry;

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             cout_d;
    logic             cout_q;

    // Every 2-bit encoding is a legal opcode, so the cast cannot produce an unnamed value.
    assign op      = alu_op_e'(ALU_Sel);
    assign sub_sel = (op == ALU_SUB);

    // One shared adder serves both ADD and SUB.
    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (A),
        .b     (B),
        .sub   (sub_sel),
        .sum   (addsub_sum),
        .carry (addsub_carry)
    );

    // Opcode mux selecting next result and carry; logic ops always clear carry.
    always_comb begin
        alu_out_d = '0;
        cout_d    = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                alu_out_d = addsub_sum;
                cout_d    = addsub_carry;
            end
            ALU_AND: begin
                alu_out_d = A & B;
                cout_d    = 1'b0;
            end
            ALU_OR: begin
                alu_out_d = A | B;
                cout_d    = 1'b0;
            end
            default: begin
                alu_out_d = '0;
                cout_d    = 1'b0;
            end
        endcase
    end

    // Output register; reset clears it immediately and drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            cout_q    <= cout_d;
        end
    end

    assign ALU_Out = alu_out_q;
    assign cOut    = cout_q;

endmodule

// File: tb/tb_alu_16.sv
module tb_alu_16;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [1:0]  sel_in;
    logic [15:0] alu_out;
    logic        c_out;

    int errors = 0;
    int checks = 0;

    alu_16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (a_in),
        .B       (b_in),
        .ALU_Sel (sel_in),
        .ALU_Out (alu_out),
        .cOut    (c_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain unsigned integer arithmetic on the operation definitions.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                             output logic [15:0] o, output logic c);
        int sa;
        int sb;
        int s;
        sa = int'(a);
        sb = int'(b);
        case (sel)
            2'd0: begin
                s = sa + sb;
                o = 16'(s % 65536);
                c = (s > 65535);
            end
            2'd1: begin
                s = sa - sb;
                if (s < 0) s = s + 65536;
                o = 16'(s);
                c = (sa >= sb);
            end
            2'd2: begin
                o = a & b;
                c = 1'b0;
            end
            default: begin
                o = a | b;
                c = 1'b0;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        sel_in = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] sel, input logic [15:0] exp_o, input logic exp_c);
        apply(a, b, sel);
        chk({tag, "_out"}, {16'h0, alu_out}, {16'h0, exp_o});
        chk({tag, "_cout"}, {31'h0, c_out}, {31'h0, exp_c});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [1:0]  rs;
        logic [15:0] mo;
        logic        mc;

        rst    = 1'b1;
        a_in   = 16'h1234;
        b_in   = 16'h1111;
        sel_in = 2'b00;
        #1;
        chk("por_out", {16'h0, alu_out}, 32'h0);
        chk("por_cout", {31'h0, c_out}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_out", {16'h0, alu_out}, 32'h2345);
        chk("post_rst_cout", {31'h0, c_out}, 32'h0);

        // Async reset mid-cycle: output clears without any clock edge.
        @(negedge clk);
        a_in = 16'hFFFF;
        b_in = 16'h0001;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", {16'h0, alu_out}, 32'h0);
        chk("async_rst_cout", {31'h0, c_out}, 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_out", {16'h0, alu_out}, 32'h0);
        chk("held_rst_cout", {31'h0, c_out}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        a_in = 16'h1234;
        b_in = 16'h1111;
        @(posedge clk);
        #1;
        chk("rel_rst_out", {16'h0, alu_out}, 32'h2345);

        // Opcode sweep, one cycle apart.
        op_check("sw_add", 16'd2, 16'd1, 2'd0, 16'd3, 1'b0);
        op_check("sw_sub", 16'd2, 16'd1, 2'd1, 16'd1, 1'b1);
        op_check("sw_and", 16'd2, 16'd1, 2'd2, 16'd0, 1'b0);
        op_check("sw_or",  16'd2, 16'd1, 2'd3, 16'd3, 1'b0);

        // Result is held between edges even when inputs change.
        @(negedge clk);
        a_in   = 16'hAAAA;
        sel_in = 2'd0;
        #1;
        chk("hold_out", {16'h0, alu_out}, 32'h3);

        // Carry / borrow boundaries.
        op_check("add_wrap", 16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1'b1);
        op_check("add_msb",  16'h8000, 16'h8000, 2'd0, 16'h0000, 1'b1);
        op_check("sub_wrap", 16'h0000, 16'h0001, 2'd1, 16'hFFFF, 1'b0);
        op_check("sub_eq",   16'h0005, 16'h0005, 2'd1, 16'h0000, 1'b1);

        // Logic ops.
        op_check("and_pat", 16'hF0F0, 16'h0FF0, 2'd2, 16'h00F0, 1'b0);
        op_check("or_pat",  16'hF0F0, 16'h0FF0, 2'd3, 16'hFFF0, 1'b0);

        // Back-to-back random operations, one per cycle, against the reference.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 2'($urandom_range(0, 3));
            if (i % 16 == 0) rb = ra;
            ref_model(ra, rb, rs, mo, mc);
            apply(ra, rb, rs);
            chk($sformatf("rnd%0d_out", i), {16'h0, alu_out}, {16'h0, mo});
            chk($sformatf("rnd%0d_cout", i), {31'h0, c_out}, {31'h0, mc});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
